// File: rtl/dcm_clkgen_prog.sv
// DCM_CLKGEN dynamic reprogramming controller.
// Shifts a new D and M into the DCM over PROGEN/PROGDATA, issues GO, then
// waits for PROGDONE and LOCKED before reporting the new ratio as in effect.
// Every wait is bounded by one shared counter, and every failure is reported
// on err. Reset asserts asynchronously; its release reaches the state
// machine only after two synchronising flops.
module dcm_clkgen_prog #(
    parameter int DEFAULT_M      = 3,
    parameter int DEFAULT_D      = 50,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] m_req,
    input  logic [8:0] d_req,
    input  logic       progdone,
    input  logic       locked,
    output logic       progen,
    output logic       progdata,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [8:0] cur_m,
    output logic [8:0] cur_d
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (TW > 13) ? TW : 13;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_D    = 3'd1;
    localparam logic [2:0] GAP1      = 3'd2;
    localparam logic [2:0] LOAD_M    = 3'd3;
    localparam logic [2:0] GAP2      = 3'd4;
    localparam logic [2:0] GO        = 3'd5;
    localparam logic [2:0] WAIT_DONE = 3'd6;
    localparam logic [2:0] WAIT_LOCK = 3'd7;

    localparam logic [CW-1:0] LOAD_LAST    = CW'(9);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [8:0] RST_M = 9'(DEFAULT_M);
    localparam logic [8:0] RST_D = 9'(DEFAULT_D);

    logic [1:0]    rst_sync_reg;
    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [8:0]    m_lat_reg, m_lat_next;
    logic [8:0]    d_lat_reg, d_lat_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [1:0]    err_reg, err_next;
    logic [8:0]    cur_m_reg, cur_m_next;
    logic [8:0]    cur_d_reg, cur_d_next;
    logic          progen_reg, progen_next;
    logic          progdata_reg, progdata_next;

    logic          req_legal;
    logic [7:0]    d_code, m_code;
    logic [9:0]    d_frame, m_frame;

    assign req_legal = (m_req >= 9'd2) && (m_req <= 9'd256) &&
                       (d_req >= 9'd1) && (d_req <= 9'd256);

    // The DCM wants value-1 in eight bits; 256 wraps to 8'hFF naturally.
    assign d_code  = d_lat_next[7:0] - 8'd1;
    assign m_code  = m_lat_next[7:0] - 8'd1;
    // Frames are sent bit 0 first: two-bit command header, then the code LSB first.
    assign d_frame = {d_code, 1'b0, 1'b1};
    assign m_frame = {m_code, 1'b1, 1'b1};

    // Reset release synchroniser: asserts immediately, releases after two edges.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    // Sequencer next-state logic; the shared counter restarts on every state change.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        m_lat_next = m_lat_reg;
        d_lat_next = d_lat_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        cur_m_next = cur_m_reg;
        cur_d_next = cur_d_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (busy_reg) begin
                    // single busy cycle that acknowledges a rejected request
                    busy_next = 1'b0;
                end else if (start) begin
                    m_lat_next = m_req;
                    d_lat_next = d_req;
                    busy_next  = 1'b1;
                    if (req_legal) begin
                        err_next   = 2'd0;
                        state_next = LOAD_D;
                    end else begin
                        err_next   = 2'd1;
                    end
                end
            end
            LOAD_D: begin
                if (cnt_reg == LOAD_LAST) begin
                    state_next = GAP1;
                    cnt_next   = '0;
                end
            end
            GAP1: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = LOAD_M;
                    cnt_next   = '0;
                end
            end
            LOAD_M: begin
                if (cnt_reg == LOAD_LAST) begin
                    state_next = GAP2;
                    cnt_next   = '0;
                end
            end
            GAP2: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = GO;
                    cnt_next   = '0;
                end
            end
            GO: begin
                state_next = WAIT_DONE;
                cnt_next   = '0;
            end
            WAIT_DONE: begin
                if (progdone) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 2'd2;
                    busy_next  = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (locked) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    cur_m_next = m_lat_reg;
                    cur_d_next = d_lat_reg;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 2'd3;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // Hold everything at reset values until the release has been synchronised.
        if (!rst_sync_reg[1]) begin
            state_next = IDLE;
            cnt_next   = '0;
            m_lat_next = '0;
            d_lat_next = '0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            err_next   = 2'd0;
            cur_m_next = RST_M;
            cur_d_next = RST_D;
        end
    end

    // PROGEN/PROGDATA for the coming cycle, derived from the next state and count.
    always_comb begin
        progen_next   = 1'b0;
        progdata_next = 1'b0;
        case (state_next)
            LOAD_D: begin
                progen_next   = 1'b1;
                progdata_next = d_frame[cnt_next[3:0]];
            end
            LOAD_M: begin
                progen_next   = 1'b1;
                progdata_next = m_frame[cnt_next[3:0]];
            end
            GO: begin
                progen_next   = 1'b1;
            end
            default: begin
                progen_next   = 1'b0;
                progdata_next = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            m_lat_reg    <= '0;
            d_lat_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 2'd0;
            cur_m_reg    <= RST_M;
            cur_d_reg    <= RST_D;
            progen_reg   <= 1'b0;
            progdata_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            m_lat_reg    <= m_lat_next;
            d_lat_reg    <= d_lat_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            cur_m_reg    <= cur_m_next;
            cur_d_reg    <= cur_d_next;
            progen_reg   <= progen_next;
            progdata_reg <= progdata_next;
        end
    end

    assign progen   = progen_reg;
    assign progdata = progdata_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign cur_m    = cur_m_reg;
    assign cur_d    = cur_d_reg;

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Testbench for dcm_clkgen_prog: scoreboard of expected request outcomes,
// a small DCM_CLKGEN behavioural model and a monitor that compares each
// completed request against the expected PROGEN/PROGDATA stream.
`timescale 1ns/1ps
module tb_dcm_clkgen_prog;

    localparam int GAP    = 2;
    localparam int TO     = 300;
    localparam int LFRAME = 21 + 2 * GAP;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] m_req = '0;
    logic [8:0] d_req = '0;
    logic       progdone = 1'b0;
    logic       locked = 1'b0;
    logic       progen, progdata, busy, done;
    logic [1:0] err;
    logic [8:0] cur_m, cur_d;

    dcm_clkgen_prog #(
        .DEFAULT_M(3),
        .DEFAULT_D(50),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clkin(clkin),
        .rst_n(rst_n),
        .start(start),
        .m_req(m_req),
        .d_req(d_req),
        .progdone(progdone),
        .locked(locked),
        .progen(progen),
        .progdata(progdata),
        .busy(busy),
        .done(done),
        .err(err),
        .cur_m(cur_m),
        .cur_d(cur_d)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        bit         legal;
        int         tx_m;
        int         tx_d;
        logic [1:0] err;
        logic       done;
        logic [8:0] cm;
        logic [8:0] cd;
        int         len;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_m  = 3;
    int   model_d  = 50;
    int   dcm_dd   = 20;
    int   dcm_ld   = 50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Expected {progen,progdata} at busy-cycle i of a request.
    function automatic logic [1:0] exp_pair(input int i, input bit legal, input int m, input int d);
        int k;
        k = i;
        if (!legal) return 2'b00;
        if (k < 10) begin
            if (k == 0) return 2'b11;
            if (k == 1) return 2'b10;
            return {1'b1, 1'(((d - 1) >> (k - 2)) & 1)};
        end
        k -= 10;
        if (k < GAP) return 2'b00;
        k -= GAP;
        if (k < 10) begin
            if (k < 2) return 2'b11;
            return {1'b1, 1'(((m - 1) >> (k - 2)) & 1)};
        end
        k -= 10;
        if (k < GAP) return 2'b00;
        k -= GAP;
        if (k == 0) return 2'b10;
        return 2'b00;
    endfunction

    // Push the predicted outcome, then pulse start for one cycle.
    task automatic issue(input int m, input int d, input int dd, input int ld);
        exp_t e;
        e.legal = (m >= 2 && m <= 256 && d >= 1 && d <= 256);
        e.tx_m  = m;
        e.tx_d  = d;
        if (!e.legal) begin
            e.err = 2'd1; e.done = 1'b0; e.len = 1;
        end else if (dd < 0) begin
            e.err = 2'd2; e.done = 1'b0; e.len = LFRAME + TO;
        end else if (ld < 0) begin
            e.err = 2'd3; e.done = 1'b0; e.len = -1;
        end else begin
            e.err = 2'd0; e.done = 1'b1; e.len = -1;
            model_m = m;
            model_d = d;
        end
        e.cm = 9'(model_m);
        e.cd = 9'(model_d);
        dcm_dd = dd;
        dcm_ld = ld;
        q.push_back(e);
        @(posedge clkin); #1;
        start = 1'b1;
        m_req = 9'(m);
        d_req = 9'(d);
        @(posedge clkin); #1;
        start = 1'b0;
        m_req = 9'($urandom);
        d_req = 9'($urandom);
        $display("request m=%0d d=%0d progdone_delay=%0d lock_delay=%0d", m, d, dd, ld);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clkin); #1;
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
        end
        repeat (3) @(posedge clkin);
        #1;
    endtask

    // DCM model: the 21st PROGEN-high cycle is GO; PROGDONE then LOCKED follow after set delays.
    initial begin
        int pcnt, dt, lt;
        pcnt = 0; dt = -1; lt = -1;
        forever begin
            @(negedge clkin);
            if (!rst_n) begin
                pcnt = 0; dt = -1; lt = -1;
                progdone = 1'b0;
                locked   = 1'b0;
            end else begin
                if (progen) begin
                    pcnt++;
                    if (pcnt == 21) begin
                        pcnt = 0;
                        progdone = 1'b0;
                        locked   = 1'b0;
                        dt = dcm_dd;
                        lt = -1;
                    end
                end
                if (dt == 0) begin
                    progdone = 1'b1;
                    dt = -1;
                    lt = dcm_ld;
                end else if (dt > 0) begin
                    dt--;
                end
                if (lt == 0) begin
                    locked = 1'b1;
                    lt = -1;
                end else if (lt > 0) begin
                    lt--;
                end
            end
        end
    end

    // Monitor: capture the stream while busy, compare on completion.
    initial begin
        logic [1:0] cap[$];
        logic       prev_busy;
        exp_t       e;
        int         bad;
        prev_busy = 1'b0;
        forever begin
            @(negedge clkin);
            if (!rst_n) begin
                cap.delete();
                prev_busy = 1'b0;
            end else begin
                if (busy) begin
                    cap.push_back({progen, progdata});
                end else if (prev_busy) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard: request completed with err=%0d but none expected", err);
                    end else begin
                        e = q.pop_front();
                        check("err", 32'(err), 32'(e.err));
                        check("done", 32'(done), 32'(e.done));
                        check("cur_m", 32'(cur_m), 32'(e.cm));
                        check("cur_d", 32'(cur_d), 32'(e.cd));
                        if (e.len >= 0) check("busy_len", cap.size(), e.len);
                        if (e.legal) check("frame_complete", 32'(cap.size() >= LFRAME), 1);
                        bad = -1;
                        for (int i = 0; i < cap.size(); i++) begin
                            if (cap[i] !== exp_pair(i, e.legal, e.tx_m, e.tx_d)) begin
                                bad = i;
                                break;
                            end
                        end
                        n_checks++;
                        if (bad >= 0) begin
                            n_fail++;
                            $display("FAIL stream: cycle %0d got progen/progdata %b, required %b (m=%0d d=%0d)",
                                     bad, cap[bad], exp_pair(bad, e.legal, e.tx_m, e.tx_d), e.tx_m, e.tx_d);
                        end
                        $display("completed m=%0d d=%0d err=%0d done=%0d cur=%0d/%0d busy_cycles=%0d",
                                 e.tx_m, e.tx_d, err, done, cur_m, cur_d, cap.size());
                    end
                    cap.delete();
                end else begin
                    check("idle_quiet", 32'({done, progen, progdata}), 0);
                end
                prev_busy = busy;
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        check("rst_progen", 32'(progen), 0);
        check("rst_progdata", 32'(progdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cur_m", 32'(cur_m), 3);
        check("rst_cur_d", 32'(cur_d), 50);
        rst_n = 1'b1;
        repeat (4) @(posedge clkin);
        #1;

        issue(1, 25, 20, 50);   wait_idle(2000);
        issue(4, 25, 20, 50);   wait_idle(2000);
        issue(256, 256, 0, 0);  wait_idle(2000);
        issue(300, 10, 5, 5);   wait_idle(2000);
        issue(10, 0, 5, 5);     wait_idle(2000);
        issue(7, 9, -1, 0);     wait_idle(2000);
        issue(5, 6, 3, -1);     wait_idle(2000);
        issue(2, 1, 1, 1);      wait_idle(2000);

        // Second start during LOAD_M must be ignored.
        issue(100, 33, 10, 10);
        repeat (14) @(posedge clkin);
        #1;
        start = 1'b1; m_req = 9'd200; d_req = 9'd3;
        @(posedge clkin); #1;
        start = 1'b0;
        wait_idle(2000);

        for (int t = 0; t < 8; t++) begin
            int m, d, sel;
            sel = int'($urandom_range(0, 5));
            m = int'($urandom_range(2, 256));
            d = int'($urandom_range(1, 256));
            if (sel == 0) m = int'($urandom_range(0, 1));
            else if (sel == 1) d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(257, 511));
            issue(m, d, int'($urandom_range(0, 30)), int'($urandom_range(0, 60)));
            wait_idle(2000);
        end

        // Reset while LOAD_D is sending data bit 5.
        issue(77, 45, 10, 10);
        repeat (7) @(posedge clkin);
        #2;
        check("pre_rst_progen", 32'(progen), 1);
        check("pre_rst_bit5", 32'(progdata), 32'(((45 - 1) >> 5) & 1));
        rst_n = 1'b0;
        #1;
        check("arst_progen", 32'(progen), 0);
        check("arst_progdata", 32'(progdata), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_err", 32'(err), 0);
        check("arst_cur_m", 32'(cur_m), 3);
        check("arst_cur_d", 32'(cur_d), 50);
        q.delete();
        model_m = 3;
        model_d = 50;
        repeat (2) @(posedge clkin);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clkin);
        #1;
        issue(9, 17, 5, 5);     wait_idle(2000);

        repeat (5) @(posedge clkin);
        #1;
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
